wb_port_arbiter: RTL and testbench

- Shares the register file's single synchronous write port between two write-back requesters: req0 (ALU/execute path) and req1 (memory/load path).
- Uses a valid/ready handshake, round-robin arbitration and a one-cycle registered write stage.
- Keeps a pending-write scoreboard so the issue stage can detect RAW hazards on rs1/rs2 before reading the register file asynchronously.
- Sits between the execute/memory stages and the register file write port.

---
 rtl/wb_port_arbiter_if.sv | 49 ++++
 rtl/wb_port_arbiter.sv | 79 +++++++
 tb/tb_wb_port_arbiter.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/wb_port_arbiter_if.sv
// rtl/wb_port_arbiter_if.sv - write-back port bundle: requesters, reservation, hazard query, RF write
interface wb_port_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic                  req0_valid;
    logic [ADDR_WIDTH-1:0] req0_rd;
    logic [DATA_WIDTH-1:0] req0_data;
    logic                  req0_ready;

    logic                  req1_valid;
    logic [ADDR_WIDTH-1:0] req1_rd;
    logic [DATA_WIDTH-1:0] req1_data;
    logic                  req1_ready;

    logic                  reserve_valid;
    logic [ADDR_WIDTH-1:0] reserve_rd;

    logic [ADDR_WIDTH-1:0] rs1;
    logic [ADDR_WIDTH-1:0] rs2;
    logic                  rs1_busy;
    logic                  rs2_busy;

    logic                  rf_we;
    logic [ADDR_WIDTH-1:0] rf_rd;
    logic [DATA_WIDTH-1:0] rf_din;

    modport master (
        output req0_valid, req0_rd, req0_data,
        input  req0_ready,
        output req1_valid, req1_rd, req1_data,
        input  req1_ready,
        output reserve_valid, reserve_rd,
        output rs1, rs2,
        input  rs1_busy, rs2_busy,
        input  rf_we, rf_rd, rf_din
    );

    modport slave (
        input  req0_valid, req0_rd, req0_data,
        output req0_ready,
        input  req1_valid, req1_rd, req1_data,
        output req1_ready,
        input  reserve_valid, reserve_rd,
        input  rs1, rs2,
        output rs1_busy, rs2_busy,
        output rf_we, rf_rd, rf_din
    );
endinterface

// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - round-robin write-back arbiter with registered RF write stage and pending scoreboard
module wb_port_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic              clk,
    input  logic              reset,
    wb_port_arbiter_if.slave  bus
);
    localparam int NREGS = 2 ** ADDR_WIDTH;

    logic                  last_grant;
    logic [NREGS-1:1]      pending;
    logic [NREGS-1:1]      pending_next;
    logic                  rf_we_q;
    logic [ADDR_WIDTH-1:0] rf_rd_q;
    logic [DATA_WIDTH-1:0] rf_din_q;

    logic                  grant0;
    logic                  grant1;
    logic                  accept;
    logic [ADDR_WIDTH-1:0] sel_rd;
    logic [DATA_WIDTH-1:0] sel_data;
    logic [NREGS-1:0]      pending_ext;

    // On contention the requester that did not win last time gets the port.
    always_comb begin
        grant0 = reset && bus.req0_valid && (!bus.req1_valid || last_grant);
        grant1 = reset && bus.req1_valid && (!bus.req0_valid || !last_grant);
        accept = grant0 || grant1;
        sel_rd   = grant1 ? bus.req1_rd   : bus.req0_rd;
        sel_data = grant1 ? bus.req1_data : bus.req0_data;
    end

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;

    // A reservation landing on the same edge as the clear belongs to a newer producer, so set wins.
    always_comb begin
        pending_next = pending;
        for (int i = 1; i < NREGS; i++) begin
            if (rf_we_q && (rf_rd_q == ADDR_WIDTH'(i))) begin
                pending_next[i] = 1'b0;
            end
            if (bus.reserve_valid && (bus.reserve_rd == ADDR_WIDTH'(i))) begin
                pending_next[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            last_grant <= 1'b1;
            pending    <= '0;
            rf_we_q    <= 1'b0;
            rf_rd_q    <= '0;
            rf_din_q   <= '0;
        end else begin
            pending <= pending_next;
            if (accept) begin
                last_grant <= grant1;
                rf_rd_q    <= sel_rd;
                rf_din_q   <= sel_data;
                rf_we_q    <= (sel_rd != '0);
            end else begin
                rf_we_q    <= 1'b0;
            end
        end
    end

    assign bus.rf_we  = rf_we_q;
    assign bus.rf_rd  = rf_rd_q;
    assign bus.rf_din = rf_din_q;

    // Bit 0 stands in for the hardwired-zero register and is never busy.
    assign pending_ext  = {pending, 1'b0};
    assign bus.rs1_busy = pending_ext[bus.rs1];
    assign bus.rs2_busy = pending_ext[bus.rs2];
endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb/tb_wb_port_arbiter.sv - scoreboard bench for wb_port_arbiter
module tb_wb_port_arbiter;
    localparam int DW = 32;
    localparam int AW = 5;

    typedef struct {
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
    } wr_t;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;
    int   grant_q[$];
    wr_t  wr_q[$];

    wb_port_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    wb_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic expect_write(input int g, input logic [AW-1:0] rd, input logic [DW-1:0] data);
        wr_t w;
        grant_q.push_back(g);
        if (rd != '0) begin
            w.rd   = rd;
            w.data = data;
            wr_q.push_back(w);
        end
    endtask

    // Monitor: every handshake and every RF write must match the next queued expectation.
    initial begin
        int  g;
        wr_t w;
        forever begin
            @(negedge clk);
            if (bus.req0_ready || bus.req1_ready) begin
                chk("one_ready", 64'(bus.req0_ready & bus.req1_ready), 64'd0);
                if (grant_q.size() == 0) begin
                    chk("grant_unexpected", 64'({bus.req0_ready, bus.req1_ready}), 64'd0);
                end else begin
                    g = grant_q.pop_front();
                    chk("grant_idx", 64'(bus.req1_ready), 64'(g));
                end
            end
            if (bus.rf_we) begin
                if (wr_q.size() == 0) begin
                    chk("rf_we_unexpected", 64'(bus.rf_rd), 64'd0);
                end else begin
                    w = wr_q.pop_front();
                    chk("rf_rd", 64'(bus.rf_rd), 64'(w.rd));
                    chk("rf_din", 64'(bus.rf_din), 64'(w.data));
                end
            end
        end
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset = 1'b0;
        bus.req0_valid = 1'b1; bus.req0_rd = 5'd1; bus.req0_data = '0;
        bus.req1_valid = 1'b1; bus.req1_rd = 5'd2; bus.req1_data = '0;
        bus.reserve_valid = 1'b0; bus.reserve_rd = '0;
        bus.rs1 = 5'd7; bus.rs2 = 5'd9;

        // Requests presented during reset must not be granted.
        for (int i = 0; i < 2; i++) begin
            sample();
            chk("rst_req0_ready", 64'(bus.req0_ready), 64'd0);
            chk("rst_req1_ready", 64'(bus.req1_ready), 64'd0);
            chk("rst_rf_we", 64'(bus.rf_we), 64'd0);
            step();
        end
        reset = 1'b1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        sample();
        chk("idle_rf_we", 64'(bus.rf_we), 64'd0);
        chk("idle_rs1_busy", 64'(bus.rs1_busy), 64'd0);
        chk("idle_rs2_busy", 64'(bus.rs2_busy), 64'd0);

        // Lone req0 write.
        step();
        bus.req0_valid = 1'b1; bus.req0_rd = 5'd5; bus.req0_data = 32'hDEADBEEF;
        expect_write(0, 5'd5, 32'hDEADBEEF);
        sample();
        chk("lone_req0_ready", 64'(bus.req0_ready), 64'd1);
        step();
        bus.req0_valid = 1'b0;
        sample();
        chk("lone_rf_we", 64'(bus.rf_we), 64'd1);
        step();
        sample();
        chk("lone_rf_we_drop", 64'(bus.rf_we), 64'd0);

        // Reset again so contention starts from req0.
        step();
        reset = 1'b0;
        step();
        reset = 1'b1;
        bus.req0_valid = 1'b1; bus.req0_rd = 5'd3; bus.req0_data = 32'hA0A0_0003;
        bus.req1_valid = 1'b1; bus.req1_rd = 5'd4; bus.req1_data = 32'hB1B1_0004;
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) expect_write(0, 5'd3, 32'hA0A0_0003);
            else            expect_write(1, 5'd4, 32'hB1B1_0004);
        end
        for (int i = 0; i < 4; i++) begin
            sample();
            step();
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        sample();
        step();

        // Write to index 0 is consumed without an RF write.
        bus.req1_valid = 1'b1; bus.req1_rd = 5'd0; bus.req1_data = 32'h0000_1234;
        expect_write(1, 5'd0, 32'h0000_1234);
        sample();
        chk("rd0_req1_ready", 64'(bus.req1_ready), 64'd1);
        step();
        bus.req1_valid = 1'b0;
        sample();
        chk("rd0_rf_we", 64'(bus.rf_we), 64'd0);
        step();

        // Reserve rd=7, then write it and watch busy fall after landing.
        bus.reserve_valid = 1'b1; bus.reserve_rd = 5'd7;
        step();
        bus.reserve_valid = 1'b0;
        bus.rs1 = 5'd7; bus.rs2 = 5'd0;
        sample();
        chk("rsv7_rs1_busy", 64'(bus.rs1_busy), 64'd1);
        chk("rs2_zero_busy", 64'(bus.rs2_busy), 64'd0);
        step();
        bus.req0_valid = 1'b1; bus.req0_rd = 5'd7; bus.req0_data = 32'h0000_0777;
        expect_write(0, 5'd7, 32'h0000_0777);
        sample();
        chk("rsv7_busy_req", 64'(bus.rs1_busy), 64'd1);
        step();
        bus.req0_valid = 1'b0;
        sample();
        chk("rsv7_busy_we", 64'(bus.rs1_busy), 64'd1);
        step();
        sample();
        chk("rsv7_busy_clear", 64'(bus.rs1_busy), 64'd0);

        // Re-reservation of rd=9 on its landing edge keeps it pending.
        step();
        bus.reserve_valid = 1'b1; bus.reserve_rd = 5'd9;
        step();
        bus.reserve_valid = 1'b0;
        bus.req0_valid = 1'b1; bus.req0_rd = 5'd9; bus.req0_data = 32'h0000_0999;
        expect_write(0, 5'd9, 32'h0000_0999);
        bus.rs2 = 5'd9;
        sample();
        chk("rsv9_busy", 64'(bus.rs2_busy), 64'd1);
        step();
        bus.req0_valid = 1'b0;
        bus.reserve_valid = 1'b1; bus.reserve_rd = 5'd9;
        sample();
        chk("rsv9_busy_we", 64'(bus.rs2_busy), 64'd1);
        step();
        bus.reserve_valid = 1'b0;
        sample();
        chk("rsv9_set_wins", 64'(bus.rs2_busy), 64'd1);

        // Reset while a write sits in the output stage.
        step();
        bus.req1_valid = 1'b1; bus.req1_rd = 5'd10; bus.req1_data = 32'h0000_00AA;
        expect_write(1, 5'd10, 32'h0000_00AA);
        bus.reserve_valid = 1'b1; bus.reserve_rd = 5'd12;
        step();
        bus.req1_valid = 1'b0;
        bus.reserve_valid = 1'b0;
        reset = 1'b0;
        bus.rs1 = 5'd12;
        sample();
        chk("rstw_rf_we_before", 64'(bus.rf_we), 64'd1);
        chk("rstw_rs1_busy_before", 64'(bus.rs1_busy), 64'd1);
        step();
        reset = 1'b1;
        sample();
        chk("rstw_rf_we_after", 64'(bus.rf_we), 64'd0);
        chk("rstw_rs1_busy_after", 64'(bus.rs1_busy), 64'd0);
        chk("rstw_rs2_busy_after", 64'(bus.rs2_busy), 64'd0);
        step();
        step();

        chk("grant_q_drained", 64'(grant_q.size()), 64'd0);
        chk("wr_q_drained", 64'(wr_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
